// File: rtl/mem_pkg.sv
// Shared definitions for memory-side buffering: ceiling-log2 helper and the
// store-to-load forwarding result record.
package mem_pkg;

  localparam int FWD_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      hit;
    logic [FWD_DATA_WIDTH-1:0] data;
  } fwd_result_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/write_buffer_fifo_youngest_match.sv
// N-way address compare with age-ordered priority: the valid entry nearest
// behind wr_ptr (the most recent push) wins.
module youngest_match
  import mem_pkg::*;
#(
  parameter int N             = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] addrs [N],
  input  logic [DATA_WIDTH-1:0]    datas [N],
  input  logic [N-1:0]             valid,
  input  logic [clog2(N)-1:0]      wr_ptr,
  input  logic [ADDRESS_WIDTH-1:0] lookup_addr,
  output logic                     hit,
  output logic [DATA_WIDTH-1:0]    data
);

  localparam int PW = clog2(N);

  logic [N-1:0] match_s;

  // Per-entry address compare qualified by occupancy.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < N; i++) begin
      match_s[i] = valid[i] && (addrs[i] == lookup_addr);
    end
  end

  // Walk from youngest (wr_ptr-1) to oldest; first match is taken.
  always_comb begin
    logic [PW-1:0] idx;
    idx  = '0;
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < N; k++) begin
      idx = wr_ptr - PW'(k) - PW'(1);
      if (!hit && match_s[idx]) begin
        hit  = 1'b1;
        data = datas[idx];
      end else begin
        hit  = hit;
      end
    end
  end

endmodule

// File: rtl/write_buffer_fifo.sv
// Store write buffer: in-order address/data FIFO with occupancy flags,
// synchronous flush and a youngest-match forwarding lookup for loads.
module write_buffer_fifo
  import mem_pkg::*;
#(
  parameter int N             = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int AF_THRESH     = N - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [clog2(N):0]        count,
  input  logic [ADDRESS_WIDTH-1:0] lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_WIDTH-1:0]    lookup_data
);

  localparam int PW = clog2(N);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(N);
  localparam logic [CW-1:0] AF_COUNT   = CW'(AF_THRESH);

  logic [ADDRESS_WIDTH-1:0] addr_mem_r [N];
  logic [DATA_WIDTH-1:0]    data_mem_r [N];
  logic [PW-1:0]            wr_ptr_r;
  logic [PW-1:0]            rd_ptr_r;
  logic [CW-1:0]            count_r;
  logic                     rd_valid_r;
  logic [ADDRESS_WIDTH-1:0] rd_addr_r;
  logic [DATA_WIDTH-1:0]    rd_data_r;

  logic                     full_s;
  logic                     empty_s;
  logic                     push_s;
  logic                     pop_s;
  logic [N-1:0]             valid_s;
  logic                     ym_hit_s;
  logic [DATA_WIDTH-1:0]    ym_data_s;
  fwd_result_t              fwd_s;

  assign full_s  = (count_r == FULL_COUNT);
  assign empty_s = (count_r == {CW{1'b0}});
  // Acceptance uses the pre-edge count, so a pop never frees room for a same-cycle push.
  assign push_s  = wr_en && !full_s;
  assign pop_s   = rd_en && !empty_s;

  // Storage write; contents survive flush and reset, only the pointers move.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_s) begin
      addr_mem_r[wr_ptr_r] <= wr_addr;
      data_mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and the one-cycle registered pop port.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      rd_valid_r <= 1'b0;
      rd_addr_r  <= '0;
      rd_data_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PW'(1);
        rd_addr_r <= addr_mem_r[rd_ptr_r];
        rd_data_r <= data_mem_r[rd_ptr_r];
      end else begin
        rd_addr_r <= '0;
        rd_data_r <= '0;
      end
      rd_valid_r <= pop_s;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // An entry is live when its distance from rd_ptr is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    off     = '0;
    valid_s = '0;
    for (int i = 0; i < N; i++) begin
      off        = PW'(i) - rd_ptr_r;
      valid_s[i] = ({1'b0, off} < count_r);
    end
  end

  youngest_match #(
    .N             (N),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_youngest_match (
    .addrs       (addr_mem_r),
    .datas       (data_mem_r),
    .valid       (valid_s),
    .wr_ptr      (wr_ptr_r),
    .lookup_addr (lookup_addr),
    .hit         (ym_hit_s),
    .data        (ym_data_s)
  );

  // Pack the forwarding result; DATA_WIDTH must not exceed FWD_DATA_WIDTH.
  always_comb begin
    fwd_s                      = '0;
    fwd_s.hit                  = ym_hit_s;
    fwd_s.data[DATA_WIDTH-1:0] = ym_data_s;
  end

  assign lookup_hit  = fwd_s.hit;
  assign lookup_data = fwd_s.data[DATA_WIDTH-1:0];

  assign rd_valid    = rd_valid_r;
  assign rd_addr     = rd_addr_r;
  assign rd_data     = rd_data_r;
  assign count       = count_r;
  assign full        = full_s;
  assign empty       = empty_s;
  assign almost_full = (count_r >= AF_COUNT);

endmodule

// File: tb/tb_write_buffer_fifo.sv
// Directed bench for write_buffer_fifo (N=4, AF_THRESH=3) with hand-computed
// expectations checked by immediate assertions.
module tb_write_buffer_fifo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic [2:0]  count;
  logic [31:0] lookup_addr;
  logic        lookup_hit;
  logic [31:0] lookup_data;

  int checks = 0;
  int errors = 0;

  write_buffer_fifo #(
    .N             (4),
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .AF_THRESH     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls, then sample 1 time unit after the edge.
  task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic re, input logic fl, input logic rs);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    flush   = fl;
    rst     = rs;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
    chk({tag, "_rd_addr"},     rd_addr,          32'd0);
    chk({tag, "_rd_data"},     rd_data,          32'd0);
    chk({tag, "_count"},       32'(count),       32'd0);
    chk({tag, "_empty"},       32'(empty),       32'd1);
    chk({tag, "_full"},        32'(full),        32'd0);
    chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, "_lookup_hit"},  32'(lookup_hit),  32'd0);
    chk({tag, "_lookup_data"}, lookup_data,      32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = 32'd0; wr_data = 32'd0; lookup_addr = 32'h0000_0010;
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk_reset_state("reset");

    // Basic ordering: three pushes then three pops.
    step(1'b1, 32'h10, 32'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h14, 32'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h18, 32'hC, 1'b0, 1'b0, 1'b0);
    chk("cnt3", 32'(count), 32'd3);
    chk("af_at3", 32'(almost_full), 32'd1);
    chk("rdv_idle", 32'(rd_valid), 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pop1_v", 32'(rd_valid), 32'd1);
    chk("pop1_a", rd_addr, 32'h10);
    chk("pop1_d", rd_data, 32'hA);
    chk("pop1_cnt", 32'(count), 32'd2);
    chk("af_at2", 32'(almost_full), 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pop2_d", rd_data, 32'hB);
    chk("pop2_cnt", 32'(count), 32'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pop3_a", rd_addr, 32'h18);
    chk("pop3_d", rd_data, 32'hC);
    chk("pop3_cnt", 32'(count), 32'd0);
    chk("pop3_empty", 32'(empty), 32'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pop_empty_v", 32'(rd_valid), 32'd0);
    chk("pop_empty_d", rd_data, 32'd0);
    chk("pop_empty_a", rd_addr, 32'd0);

    // Fill to full, overflow push, then push+pop at full.
    step(1'b1, 32'h30, 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h34, 32'h2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h38, 32'h3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3C, 32'h4, 1'b0, 1'b0, 1'b0);
    chk("full_cnt", 32'(count), 32'd4);
    chk("full_flag", 32'(full), 32'd1);
    step(1'b1, 32'h99, 32'h99, 1'b0, 1'b0, 1'b0);
    chk("ovf_cnt", 32'(count), 32'd4);
    lookup_addr = 32'h99; #1;
    chk("ovf_lookup", 32'(lookup_hit), 32'd0);
    lookup_addr = 32'h3C; #1;
    chk("full_lookup_hit", 32'(lookup_hit), 32'd1);
    chk("full_lookup_d", lookup_data, 32'h4);
    step(1'b1, 32'hAA, 32'hAA, 1'b1, 1'b0, 1'b0);
    chk("fullpp_cnt", 32'(count), 32'd3);
    chk("fullpp_v", 32'(rd_valid), 32'd1);
    chk("fullpp_a", rd_addr, 32'h30);
    chk("fullpp_d", rd_data, 32'h1);
    chk("fullpp_full", 32'(full), 32'd0);
    chk("fullpp_af", 32'(almost_full), 32'd1);
    lookup_addr = 32'hAA; #1;
    chk("fullpp_lookup", 32'(lookup_hit), 32'd0);

    // Down to two entries, then ten push+pop cycles across the wrap.
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("drain_d", rd_data, 32'h2);
    chk("drain_cnt", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h200 + 32'(i), 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
      chk("pp_cnt", 32'(count), 32'd2);
      chk("pp_v", 32'(rd_valid), 32'd1);
      chk("pp_d", rd_data, (i < 2) ? 32'h3 + 32'(i) : 32'h100 + 32'(i - 2));
    end
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pp_tail1_a", rd_addr, 32'h208);
    chk("pp_tail1_d", rd_data, 32'h108);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pp_tail2_d", rd_data, 32'h109);
    chk("pp_tail2_cnt", 32'(count), 32'd0);

    // Push+pop at empty: pop ignored, push kept. Then youngest-match forwarding.
    step(1'b1, 32'h20, 32'h1, 1'b1, 1'b0, 1'b0);
    chk("emptypp_cnt", 32'(count), 32'd1);
    chk("emptypp_v", 32'(rd_valid), 32'd0);
    step(1'b1, 32'h20, 32'h2, 1'b0, 1'b0, 1'b0);
    lookup_addr = 32'h20; #1;
    chk("fwd_hit", 32'(lookup_hit), 32'd1);
    chk("fwd_young", lookup_data, 32'h2);
    lookup_addr = 32'h21; #1;
    chk("fwd_other_miss", 32'(lookup_hit), 32'd0);
    chk("fwd_other_data", lookup_data, 32'd0);
    lookup_addr = 32'h20;
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("fwd_pop1_d", rd_data, 32'h1);
    chk("fwd_pop1_hit", 32'(lookup_hit), 32'd1);
    chk("fwd_pop1_data", lookup_data, 32'h2);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("fwd_pop2_hit", 32'(lookup_hit), 32'd0);
    chk("fwd_pop2_data", lookup_data, 32'd0);

    // Flush with simultaneous push and pop at count 3.
    step(1'b1, 32'h40, 32'h7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 32'h8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h48, 32'h9, 1'b0, 1'b0, 1'b0);
    lookup_addr = 32'h44; #1;
    chk("preflush_hit", 32'(lookup_hit), 32'd1);
    chk("preflush_data", lookup_data, 32'h8);
    step(1'b1, 32'h4C, 32'hA, 1'b1, 1'b1, 1'b0);
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_v", 32'(rd_valid), 32'd0);
    chk("flush_d", rd_data, 32'd0);
    chk("flush_lookup", 32'(lookup_hit), 32'd0);

    // Reset in the middle of a drain.
    step(1'b1, 32'h50, 32'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h54, 32'h6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h58, 32'h7, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("middrain_d", rd_data, 32'h5);
    lookup_addr = 32'h54;
    step(1'b1, 32'h5C, 32'h8, 1'b1, 1'b0, 1'b1);
    chk_reset_state("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
